// File: rtl/seg7_bcd_display.sv
// Binary-to-decimal 7-segment display driver.
// A sequential double-dabble turns value_i into DIGITS BCD nibbles, one bit per clock, then
// latches decoded glyphs for all digits in one cycle so the display never shows a partial
// result. Supports leading-zero blanking, overflow dashes, either segment polarity and
// conversion on load_i or automatically whenever value_i changes.
module seg7_bcd_display #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIGITS     = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          LEAD_BLANK = 1'b1,
  parameter bit          AUTO       = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   value_i,
  input  logic                load_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovf_o,
  output logic [7*DIGITS-1:0] seg_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  // Largest value that fits in DIGITS decimal digits; 10^10 still fits in 64 bits.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  // Glyph table is written in the lit-low form of the DE-series boards.
  localparam logic [6:0] GLYPH_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] GLYPH_DASH  = ACTIVE_LOW ? 7'h3F : 7'h40;

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("seg7_bcd_display: DATA_W must be 1..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("seg7_bcd_display: DIGITS must be 1..10");
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return ACTIVE_LOW ? g : ~g;
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] last_q;
  logic [SEG_W-1:0]  seg_q;
  logic              ovf_q;
  logic              done_q;

  logic              start;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [DATA_W-1:0] sreg_shift;
  logic              ovf_next;
  logic [SEG_W-1:0]  seg_next;

  // Start condition: value change in auto mode, explicit strobe otherwise; only from idle.
  always_comb begin
    start = 1'b0;
    if (state_q == StIdle) begin
      start = AUTO ? (value_i != last_q) : load_i;
    end
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, sreg} left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    bcd_shift  = {bcd_adj[BCD_W-2:0], sreg_q[DATA_W-1]};
    sreg_shift = sreg_q << 1;
  end

  // Glyph decode of the finished BCD word, scanning from the top digit for blanking.
  always_comb begin
    logic seen_nz;
    ovf_next = {{(64 - DATA_W){1'b0}}, last_q} > MAX_VAL;
    seg_next = '0;
    seen_nz  = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      if (ovf_next) begin
        seg_next[7*k +: 7] = GLYPH_DASH;
      end else if (LEAD_BLANK && !seen_nz && k != 0) begin
        seg_next[7*k +: 7] = GLYPH_BLANK;
      end else begin
        seg_next[7*k +: 7] = glyph(bcd_q[4*k +: 4]);
      end
    end
  end

  // Conversion FSM with registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      seg_q   <= {DIGITS{GLYPH_BLANK}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sreg_q  <= value_i;
            last_q  <= value_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(DATA_W);
            state_q <= StShift;
          end
        end
        StShift: begin
          bcd_q  <= bcd_shift;
          sreg_q <= sreg_shift;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StLatch;
          end
        end
        StLatch: begin
          seg_q   <= seg_next;
          ovf_q   <= ovf_next;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench: five configurations share clock and reset; four AUTO=0 instances share
// one value/load pair, the AUTO=1 instance has its own value input.
module tb_seg7_bcd_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic load = 1'b0;
  logic [7:0] val_d = 8'd0;

  int checks = 0;
  int errors = 0;

  // A: 3 digits, blanking; B: no blanking; C: 2 digits; D: auto; E: active-high.
  logic busy_a, done_a, ovf_a; logic [20:0] seg_a;
  logic busy_b, done_b, ovf_b; logic [20:0] seg_b;
  logic busy_c, done_c, ovf_c; logic [13:0] seg_c;
  logic busy_d, done_d, ovf_d; logic [20:0] seg_d;
  logic busy_e, done_e, ovf_e; logic [20:0] seg_e;

  always #5 clk = ~clk;

  seg7_bcd_display #(.DATA_W(8), .DIGITS(3), .ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b1),
                     .AUTO(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
    .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a), .seg_o(seg_a));

  seg7_bcd_display #(.DATA_W(8), .DIGITS(3), .ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b0),
                     .AUTO(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
    .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b), .seg_o(seg_b));

  seg7_bcd_display #(.DATA_W(8), .DIGITS(2), .ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b1),
                     .AUTO(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
    .busy_o(busy_c), .done_o(done_c), .ovf_o(ovf_c), .seg_o(seg_c));

  seg7_bcd_display #(.DATA_W(8), .DIGITS(3), .ACTIVE_LOW(1'b1), .LEAD_BLANK(1'b1),
                     .AUTO(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .value_i(val_d), .load_i(1'b0),
    .busy_o(busy_d), .done_o(done_d), .ovf_o(ovf_d), .seg_o(seg_d));

  seg7_bcd_display #(.DATA_W(8), .DIGITS(3), .ACTIVE_LOW(1'b0), .LEAD_BLANK(1'b1),
                     .AUTO(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
    .busy_o(busy_e), .done_o(done_e), .ovf_o(ovf_e), .seg_o(seg_e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start edge E0, then nine more edges: sampling point is just after E9.
  task automatic do_load(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
    repeat (9) step();
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    logic [20:0] first_seg;

    // 1: reset holds everything blank and idle
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_seg_a", 64'(seg_a), 64'(21'h1FFFFF));
      chk("rst_seg_e", 64'(seg_e), 64'(21'h0));
      chk("rst_flags_a", 64'({busy_a, done_a, ovf_a}), 64'(3'b000));
    end
    rst_n = 1'b1;
    step();

    // 2: 255 with exact latency
    value = 8'd255;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk("lat_busy_e0", 64'(busy_a), 64'(1'b1));
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("lat_no_done", 64'(done_a), 64'(1'b0));
      chk("lat_seg_hold", 64'(seg_a), 64'(21'h1FFFFF));
      chk("lat_busy", 64'(busy_a), 64'(1'b1));
    end
    step();
    chk("v255_done", 64'(done_a), 64'(1'b1));
    chk("v255_busy", 64'(busy_a), 64'(1'b0));
    chk("v255_seg_a", 64'(seg_a), 64'({7'h24, 7'h12, 7'h12}));
    chk("v255_ovf_a", 64'(ovf_a), 64'(1'b0));
    chk("v255_seg_b", 64'(seg_b), 64'({7'h24, 7'h12, 7'h12}));
    chk("v255_seg_c", 64'(seg_c), 64'({7'h3F, 7'h3F}));
    chk("v255_ovf_c", 64'(ovf_c), 64'(1'b1));
    chk("v255_seg_e", 64'(seg_e), 64'({7'h5B, 7'h6D, 7'h6D}));
    step();
    chk("v255_done_pulse", 64'(done_a), 64'(1'b0));

    // 3: leading-zero blanking
    step();
    do_load(8'd7);
    chk("v7_done", 64'(done_a), 64'(1'b1));
    chk("v7_seg_a", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'h78}));
    chk("v7_seg_b", 64'(seg_b), 64'({7'h40, 7'h40, 7'h78}));
    chk("v7_seg_c", 64'(seg_c), 64'({7'h7F, 7'h78}));
    chk("v7_ovf_c", 64'(ovf_c), 64'(1'b0));
    chk("v7_seg_e", 64'(seg_e), 64'({7'h00, 7'h00, 7'h07}));
    step();
    do_load(8'd0);
    chk("v0_seg_a", 64'(seg_a), 64'({7'h7F, 7'h7F, 7'h40}));
    chk("v0_seg_b", 64'(seg_b), 64'({7'h40, 7'h40, 7'h40}));
    step();
    do_load(8'd50);
    chk("v50_seg_a", 64'(seg_a), 64'({7'h7F, 7'h12, 7'h40}));
    chk("v50_seg_c", 64'(seg_c), 64'({7'h12, 7'h40}));

    // 4: two-digit overflow boundary
    step();
    do_load(8'd100);
    chk("v100_seg_c", 64'(seg_c), 64'({7'h3F, 7'h3F}));
    chk("v100_ovf_c", 64'(ovf_c), 64'(1'b1));
    chk("v100_seg_a", 64'(seg_a), 64'({7'h79, 7'h40, 7'h40}));
    step();
    do_load(8'd99);
    chk("v99_seg_c", 64'(seg_c), 64'({7'h10, 7'h10}));
    chk("v99_ovf_c", 64'(ovf_c), 64'(1'b0));
    chk("v99_seg_a", 64'(seg_a), 64'({7'h7F, 7'h10, 7'h10}));

    // 5a: load while busy is ignored
    step();
    value = 8'd42;
    load  = 1'b1;
    step();
    load  = 1'b0;
    step();
    step();
    value = 8'd99;
    load  = 1'b1;
    step();
    load  = 1'b0;
    repeat (6) step();
    chk("busyload_done", 64'(done_a), 64'(1'b1));
    chk("busyload_seg", 64'(seg_a), 64'({7'h7F, 7'h19, 7'h24}));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_a) pulses++;
    end
    chk("busyload_pulses", 64'(pulses), 64'(0));
    chk("busyload_hold", 64'(seg_a), 64'({7'h7F, 7'h19, 7'h24}));

    // 5b: auto mode picks up a mid-conversion change
    val_d = 8'd12;
    step();
    pulses = 0;
    first_at = -1;
    second_at = -1;
    first_seg = '0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) val_d = 8'd34;
      step();
      if (done_d) begin
        pulses++;
        if (pulses == 1) begin
          first_at = i;
          first_seg = seg_d;
        end else if (pulses == 2) begin
          second_at = i;
        end
      end
    end
    chk("auto_pulses", 64'(pulses), 64'(2));
    chk("auto_first_at", 64'(first_at), 64'(9));
    chk("auto_second_at", 64'(second_at), 64'(19));
    chk("auto_first_seg", 64'(first_seg), 64'({7'h7F, 7'h79, 7'h24}));
    chk("auto_final_seg", 64'(seg_d), 64'({7'h7F, 7'h30, 7'h19}));

    // 6: reset in the middle of a shift
    val_d = 8'd0;
    do_load(8'd150);
    chk("pre_rst_ovf_c", 64'(ovf_c), 64'(1'b1));
    step();
    value = 8'd200;
    load  = 1'b1;
    step();
    load  = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_seg_a", 64'(seg_a), 64'(21'h1FFFFF));
    chk("midrst_seg_c", 64'(seg_c), 64'(14'h3FFF));
    chk("midrst_flags_a", 64'({busy_a, done_a, ovf_a}), 64'(3'b000));
    chk("midrst_ovf_c", 64'(ovf_c), 64'(1'b0));
    step();
    rst_n = 1'b1;
    step();
    value = 8'd128;
    load  = 1'b1;
    step();
    load  = 1'b0;
    repeat (8) step();
    chk("v128_early", 64'(done_a), 64'(1'b0));
    step();
    chk("v128_done", 64'(done_a), 64'(1'b1));
    chk("v128_seg_a", 64'(seg_a), 64'({7'h79, 7'h24, 7'h00}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
